// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin line arbiter in front of the memory controller
// Serialises icache fills and dcache fills/writebacks with a mandatory op-release cycle and a watchdog.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int TO_W   = 20
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_done,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_done,
  output logic              d_err,
  output logic              mem_read_op,
  output logic              mem_write_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_busy,
  input  logic              mem_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BUSY_I = 2'd1,
    S_BUSY_D = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_prio_d;
  logic [TO_W-1:0]   r_wd;
  logic [TO_W-1:0]   w_wd_inc;
  logic              w_grant_i;
  logic              w_grant_d;
  logic              w_finish;
  logic              w_timeout;
  logic              w_unused;

  // Low address bits are dropped by line alignment; busy is informational only.
  assign w_unused = ^{mem_busy, i_addr[4:0], d_addr[4:0]};
  assign w_wd_inc = r_wd + TO_W'(1);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    w_finish     = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (d_req && (!i_req || r_prio_d)) begin
          w_grant_d    = 1'b1;
          w_state_next = S_BUSY_D;
        end else if (i_req) begin
          w_grant_i    = 1'b1;
          w_state_next = S_BUSY_I;
        end
      end
      S_BUSY_I, S_BUSY_D: begin
        // A done coinciding with the watchdog wrap wins over the timeout.
        if (mem_done) begin
          w_finish     = 1'b1;
          w_state_next = S_RESP;
        end else if (w_wd_inc == '1) begin
          w_timeout    = 1'b1;
          w_state_next = S_RESP;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_prio_d     <= 1'b1;
      r_wd         <= '0;
      mem_read_op  <= 1'b0;
      mem_write_op <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
      i_done       <= 1'b0;
      i_err        <= 1'b0;
      d_done       <= 1'b0;
      d_err        <= 1'b0;
    end else begin
      i_done <= 1'b0;
      i_err  <= 1'b0;
      d_done <= 1'b0;
      d_err  <= 1'b0;

      if (w_grant_i || w_grant_d) begin
        r_wd <= '0;
      end else if (r_state == S_BUSY_I || r_state == S_BUSY_D) begin
        r_wd <= w_wd_inc;
      end

      if (w_grant_i) begin
        mem_addr    <= {i_addr[ADDR_W-1:5], 5'b0};
        mem_read_op <= 1'b1;
      end

      if (w_grant_d) begin
        mem_addr     <= {d_addr[ADDR_W-1:5], 5'b0};
        mem_wdata    <= d_wdata;
        mem_read_op  <= !d_we;
        mem_write_op <= d_we;
      end

      if (w_finish || w_timeout) begin
        mem_read_op  <= 1'b0;
        mem_write_op <= 1'b0;
        r_prio_d     <= (r_state == S_BUSY_I);
        if (r_state == S_BUSY_I) begin
          i_done <= 1'b1;
          i_err  <= w_timeout;
          if (w_finish) begin
            i_rdata <= mem_rdata;
          end
        end else begin
          d_done <= 1'b1;
          d_err  <= w_timeout;
          if (w_finish && mem_read_op) begin
            d_rdata <= mem_rdata;
          end
        end
      end
    end
  end

endmodule
